// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, reads the asynchronous program memory,
// and hands each instruction downstream through a one-entry valid/ready register.
module instruction_fetch_unit #(
  parameter logic [7:0] PC_RESET  = 8'd0,
  parameter logic [7:0] LAST_ADDR = 8'd10,
  parameter int         INSTR_W   = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [7:0]         pm_addr,
  input  logic [INSTR_W-1:0] pm_data,
  input  logic               redirect_valid,
  input  logic [7:0]         redirect_addr,
  input  logic               ir_ready,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [7:0]         ir_pc,
  output logic [4:0]         ir_opcode,
  output logic [2:0]         ir_dr,
  output logic [2:0]         ir_sa,
  output logic [2:0]         ir_sb,
  output logic [2:0]         ir_sh,
  output logic [5:0]         ir_imm,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [7:0]           r_pc;
  logic                 r_ir_valid;
  logic [INSTR_W-1:0]   r_ir_instr;
  logic [7:0]           r_ir_pc;

  logic                 w_redirect;
  logic                 w_restart;
  logic                 w_load;
  logic                 w_at_last;

  // Redirect is dead in IDLE; everywhere else it overrides fetch, consume and start.
  assign w_redirect = redirect_valid && (r_state != S_IDLE);
  assign w_restart  = start && ((r_state == S_IDLE) || (r_state == S_DONE)) && !w_redirect;
  assign w_load     = (r_state == S_RUN) && !w_redirect && (!r_ir_valid || ir_ready);
  assign w_at_last  = (r_pc == LAST_ADDR);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_redirect)               w_state_next = S_RUN;
        else if (w_load && w_at_last) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_redirect)                    w_state_next = S_RUN;
        else if (!r_ir_valid || ir_ready)  w_state_next = S_DONE;
      end
      S_DONE: begin
        if (w_redirect || start) w_state_next = S_RUN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_RUN, S_DRAIN: busy = 1'b1;
      S_DONE:         done = 1'b1;
      default: ;
    endcase
  end

  // Program counter: the last-address compare above uses the pre-increment value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= PC_RESET;
    end else if (w_redirect) begin
      r_pc <= redirect_addr;
    end else if (w_restart) begin
      r_pc <= PC_RESET;
    end else if (w_load) begin
      r_pc <= r_pc + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_valid <= 1'b0;
    end else if (w_redirect) begin
      r_ir_valid <= 1'b0;
    end else if (w_load) begin
      r_ir_valid <= 1'b1;
    end else if (ir_ready) begin
      r_ir_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_instr <= '0;
      r_ir_pc    <= 8'd0;
    end else if (w_load) begin
      r_ir_instr <= pm_data;
      r_ir_pc    <= r_pc;
    end
  end

  assign pm_addr   = r_pc;
  assign ir_valid  = r_ir_valid;
  assign ir_instr  = r_ir_instr;
  assign ir_pc     = r_ir_pc;

  // IMM deliberately overlaps SB/SH; decode picks whichever the opcode needs.
  assign ir_opcode = r_ir_instr[16:12];
  assign ir_dr     = r_ir_instr[11:9];
  assign ir_sa     = r_ir_instr[8:6];
  assign ir_sb     = r_ir_instr[5:3];
  assign ir_sh     = r_ir_instr[2:0];
  assign ir_imm    = r_ir_instr[5:0];

endmodule
